// File: rtl/serial_byte_rx_if.sv
// Bundle of serial receiver signals
//   rx          serial line into the receiver (idle high)
//   data_out    last received byte, [0] is the first data bit on the line
//   data_valid  one-cycle pulse when data_out and the error flags update
//   parity_err  parity mismatch on the last frame
//   frame_err   stop bit of the last frame sampled low
//   busy        receiver is not idle
// master: the side that drives the line and consumes the results
// slave : the receiver itself
interface serial_byte_rx_if;
    logic       rx;
    logic [0:7] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_byte_rx.sv
// Serial byte receiver feeding the byte parity checker.
// Frame on the line: start(0), 8 data bits (bit 0 first), parity, stop(1).
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_byte_rx_if.slave: rx in; data_out, data_valid,
//          parity_err, frame_err, busy out
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | confirm start bit at its centre (glitch filter)
// DATA   | sample 8 data bits at bit centres
// PARITY | sample parity bit
// STOP   | sample stop bit, publish byte and flags
// BREAK  | stop bit was low; wait for line to return high
module serial_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_byte_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic             PAR_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [0:7]       shift_reg;
    logic             par_bit;
    logic             rx_m;
    logic             rx_s;

    // Synchronizer resets to the idle line level so reset release never
    // looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            shift_reg      <= '0;
            par_bit        <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shift_reg[idx] <= rx_s;
                        if (idx == 3'd7) state <= PARITY;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        bus.data_out   <= shift_reg;
                        bus.data_valid <= 1'b1;
                        bus.parity_err <= (((^shift_reg) ^ par_bit) != PAR_SENSE);
                        bus.frame_err  <= ~rx_s;
                        // A low stop bit parks in BREAK so a held-low line
                        // cannot be mistaken for the next start bit.
                        if (rx_s) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx (CLKS_PER_BIT=16, even parity).
module tb_serial_byte_rx;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   nvalid;
    int   vcyc  [0:15];
    logic [0:7] vdata [0:15];
    logic vperr [0:15];
    logic vferr [0:15];
    int   n0;

    serial_byte_rx_if bus ();

    serial_byte_rx #(.CLKS_PER_BIT(16), .PARITY_ODD(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every data_valid pulse with its cycle and the published values.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            vcyc[nvalid % 16]  = cyc;
            vdata[nvalid % 16] = bus.data_out;
            vperr[nvalid % 16] = bus.parity_err;
            vferr[nvalid % 16] = bus.frame_err;
            nvalid = nvalid + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_bit(input logic v);
        bus.rx = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [0:7] d, input logic p, input logic stp);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        rx_bit(p);
        rx_bit(stp);
    endtask

    logic [0:7] b;

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        nvalid = 0;
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data_out",   32'(bus.data_out),   32'h00);
        chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
        chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'h0);
        chk("rst_busy",       32'(bus.busy),       32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: clean frame 10110010, four ones, even parity bit 0
        n0 = nvalid;
        b  = 8'b10110010;
        send_frame(b, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t1_count",  32'(nvalid), 32'(n0 + 1));
        chk("t1_data",   32'(vdata[n0 % 16]), 32'hB2);
        chk("t1_perr",   32'(vperr[n0 % 16]), 32'h0);
        chk("t1_ferr",   32'(vferr[n0 % 16]), 32'h0);
        chk("t1_busy",   32'(bus.busy), 32'h0);

        // 2: same byte, wrong parity
        n0 = nvalid;
        send_frame(b, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2_count",  32'(nvalid), 32'(n0 + 1));
        chk("t2_data",   32'(vdata[n0 % 16]), 32'hB2);
        chk("t2_perr",   32'(vperr[n0 % 16]), 32'h1);
        chk("t2_ferr",   32'(vferr[n0 % 16]), 32'h0);

        // 3: 0xFF with low stop bit, line held low for 3 more bit times
        n0 = nvalid;
        b  = 8'hFF;
        send_frame(b, 1'b0, 1'b0);
        repeat (48) @(negedge clk);
        chk("t3_count",  32'(nvalid), 32'(n0 + 1));
        chk("t3_data",   32'(vdata[n0 % 16]), 32'hFF);
        chk("t3_perr",   32'(vperr[n0 % 16]), 32'h0);
        chk("t3_ferr",   32'(vferr[n0 % 16]), 32'h1);
        chk("t3_busy_low_line", 32'(bus.busy), 32'h1);
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_busy_released", 32'(bus.busy), 32'h0);
        chk("t3_no_second", 32'(nvalid), 32'(n0 + 1));

        // 4: 4-clk glitch must be rejected, flags held from frame 3
        n0 = nvalid;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_count", 32'(nvalid), 32'(n0));
        chk("t4_busy",  32'(bus.busy), 32'h0);
        chk("t4_ferr_held", 32'(bus.frame_err), 32'h1);
        chk("t4_data_held", 32'(bus.data_out), 32'hFF);

        // 5: reset in the middle of data bit 4, then a clean frame
        n0 = nvalid;
        rx_bit(1'b0);
        for (int i = 0; i < 4; i++) rx_bit(1'b1);
        bus.rx = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_busy_mid", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_data", 32'(bus.data_out),  32'h00);
        chk("t5_rst_ferr", 32'(bus.frame_err), 32'h0);
        chk("t5_rst_busy", 32'(bus.busy),      32'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_valid_aborted", 32'(nvalid), 32'(n0));
        b = 8'b00000001;
        send_frame(b, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_count", 32'(nvalid), 32'(n0 + 1));
        chk("t5_data",  32'(vdata[n0 % 16]), 32'h01);
        chk("t5_perr",  32'(vperr[n0 % 16]), 32'h0);
        chk("t5_ferr",  32'(vferr[n0 % 16]), 32'h0);

        // 6: back-to-back frames; a frame is 11 bits, so pulses are 176 clk apart
        n0 = nvalid;
        b  = 8'b10101010;
        send_frame(b, 1'b0, 1'b1);
        b  = 8'b11100000;
        send_frame(b, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_count", 32'(nvalid), 32'(n0 + 2));
        chk("t6_data0", 32'(vdata[n0 % 16]), 32'hAA);
        chk("t6_perr0", 32'(vperr[n0 % 16]), 32'h0);
        chk("t6_ferr0", 32'(vferr[n0 % 16]), 32'h0);
        chk("t6_data1", 32'(vdata[(n0 + 1) % 16]), 32'hE0);
        chk("t6_perr1", 32'(vperr[(n0 + 1) % 16]), 32'h0);
        chk("t6_ferr1", 32'(vferr[(n0 + 1) % 16]), 32'h0);
        chk("t6_spacing", 32'(vcyc[(n0 + 1) % 16] - vcyc[n0 % 16]), 32'd176);
        chk("t6_busy_end", 32'(bus.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
